// File: rtl/axis_input_dma_sequencer.sv
// ---------------------------------------------------------------------------
// axis_input_dma_sequencer
//
// Splits the single shared input DMA stream into the three input-pipe slave
// streams (weights, pixels_1, pixels_2). A job is one layer/tile: first the
// weight beats, then (cfg_blocks_1 + 1) repetitions of one pixels_1 packet
// followed by one pixels_2 packet. Routing is purely combinational with no
// buffering, so a beat reaches its destination in the same cycle it is
// presented. tlast on each destination is generated from internal counters.
// The incoming tlast is only compared against the generated one.
//
// Ports
//   i_aclk, i_areset            clock, synchronous active-high reset
//   i_start                     pulse: latch i_cfg_* and begin a job (IDLE only)
//   i_cfg_w_beats_1             weight beats in job, minus 1
//   i_cfg_px_beats_1            beats per pixel packet, minus 1
//   i_cfg_blocks_1              (pixels_1, pixels_2) pairs in job, minus 1
//   o_busy                      high from accepted start until done
//   o_done                      one-cycle pulse after the job's final beat
//   o_err_tlast                 sticky tlast-mismatch flag, cleared by start
//   o_state                     current FSM state (debug)
//   i_s_axis_* / o_s_axis_tready  shared input stream
//   o_m_w_*   / i_m_w_tready      weight rotator stream
//   o_m_p1_*  / i_m_p1_tready     pixels_1 stream
//   o_m_p2_*  / i_m_p2_tready     pixels_2 stream
//
// Handshake semantics on every stream: a beat transfers on a rising edge
// where tvalid && tready are both high. o_s_axis_tready is derived only from
// the selected sink's tready and the FSM state, never from any tvalid, so no
// combinational loop is formed through this block.
// ---------------------------------------------------------------------------
module axis_input_dma_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int BEATS_BITS  = 16,
    parameter int BLOCKS_BITS = 8
) (
    input  logic                   i_aclk,
    input  logic                   i_areset,
    input  logic                   i_start,
    input  logic [BEATS_BITS-1:0]  i_cfg_w_beats_1,
    input  logic [BEATS_BITS-1:0]  i_cfg_px_beats_1,
    input  logic [BLOCKS_BITS-1:0] i_cfg_blocks_1,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err_tlast,
    output logic [1:0]             o_state,
    output logic                   o_s_axis_tready,
    input  logic                   i_s_axis_tvalid,
    input  logic                   i_s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]  i_s_axis_tdata,
    input  logic                   i_m_w_tready,
    output logic                   o_m_w_tvalid,
    output logic                   o_m_w_tlast,
    output logic [DATA_WIDTH-1:0]  o_m_w_tdata,
    input  logic                   i_m_p1_tready,
    output logic                   o_m_p1_tvalid,
    output logic                   o_m_p1_tlast,
    output logic [DATA_WIDTH-1:0]  o_m_p1_tdata,
    input  logic                   i_m_p2_tready,
    output logic                   o_m_p2_tvalid,
    output logic                   o_m_p2_tlast,
    output logic [DATA_WIDTH-1:0]  o_m_p2_tdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WEIGHTS = 2'd1,
        S_PIX1    = 2'd2,
        S_PIX2    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [BEATS_BITS-1:0]  r_beat_cnt;
    logic [BLOCKS_BITS-1:0] r_block_cnt;
    logic [BEATS_BITS-1:0]  r_w_beats_1;
    logic [BEATS_BITS-1:0]  r_px_beats_1;
    logic [BLOCKS_BITS-1:0] r_blocks_1;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err_tlast;

    logic [BEATS_BITS-1:0]  w_limit;
    logic                   w_at_limit;
    logic                   w_sel_ready;
    logic                   w_hs;
    logic                   w_gen_tlast;

    // Packet length for the current destination.
    assign w_limit     = (r_state == S_WEIGHTS) ? r_w_beats_1 : r_px_beats_1;
    assign w_at_limit  = (r_beat_cnt == w_limit);
    assign w_gen_tlast = w_at_limit && (r_state != S_IDLE);

    always_comb begin
        w_sel_ready = 1'b0;
        case (r_state)
            S_WEIGHTS: w_sel_ready = i_m_w_tready;
            S_PIX1:    w_sel_ready = i_m_p1_tready;
            S_PIX2:    w_sel_ready = i_m_p2_tready;
            default:   w_sel_ready = 1'b0;
        endcase
    end

    assign w_hs = i_s_axis_tvalid && w_sel_ready;

    assign o_s_axis_tready = w_sel_ready;

    assign o_m_w_tvalid  = i_s_axis_tvalid && (r_state == S_WEIGHTS);
    assign o_m_p1_tvalid = i_s_axis_tvalid && (r_state == S_PIX1);
    assign o_m_p2_tvalid = i_s_axis_tvalid && (r_state == S_PIX2);

    assign o_m_w_tlast   = (r_state == S_WEIGHTS) && w_at_limit;
    assign o_m_p1_tlast  = (r_state == S_PIX1) && w_at_limit;
    assign o_m_p2_tlast  = (r_state == S_PIX2) && w_at_limit;

    assign o_m_w_tdata   = i_s_axis_tdata;
    assign o_m_p1_tdata  = i_s_axis_tdata;
    assign o_m_p2_tdata  = i_s_axis_tdata;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_tlast = r_err_tlast;
    assign o_state     = r_state;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_block_cnt  <= '0;
            r_w_beats_1  <= '0;
            r_px_beats_1 <= '0;
            r_blocks_1   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_tlast  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_w_beats_1  <= i_cfg_w_beats_1;
                        r_px_beats_1 <= i_cfg_px_beats_1;
                        r_blocks_1   <= i_cfg_blocks_1;
                        r_beat_cnt   <= '0;
                        r_block_cnt  <= '0;
                        r_err_tlast  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_WEIGHTS;
                    end
                end
                default: begin
                    if (w_hs) begin
                        // The incoming tlast is advisory: a mismatch is
                        // recorded but sequencing follows the counters.
                        if (i_s_axis_tlast != w_gen_tlast) begin
                            r_err_tlast <= 1'b1;
                        end
                        if (w_at_limit) begin
                            r_beat_cnt <= '0;
                            case (r_state)
                                S_WEIGHTS: r_state <= S_PIX1;
                                S_PIX1:    r_state <= S_PIX2;
                                default: begin
                                    if (r_block_cnt == r_blocks_1) begin
                                        r_state <= S_IDLE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                    end else begin
                                        r_block_cnt <= r_block_cnt + 1'b1;
                                        r_state     <= S_PIX1;
                                    end
                                end
                            endcase
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_input_dma_sequencer.sv
`timescale 1ns/1ps
module tb_axis_input_dma_sequencer;

    localparam int DW = 64;

    // ---------------- clock / reset / DUT signals ----------------
    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   cfg_w = '0;
    logic [15:0]   cfg_px = '0;
    logic [7:0]    cfg_bl = '0;
    logic          busy, done, err_tlast;
    logic [1:0]    state;
    logic          s_tready;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          w_tready = 1'b1, p1_tready = 1'b1, p2_tready = 1'b1;
    logic          w_tvalid, w_tlast, p1_tvalid, p1_tlast, p2_tvalid, p2_tlast;
    logic [DW-1:0] w_tdata, p1_tdata, p2_tdata;

    always #5 clk = ~clk;

    axis_input_dma_sequencer #(.DATA_WIDTH(DW), .BEATS_BITS(16), .BLOCKS_BITS(8)) dut (
        .i_aclk(clk), .i_areset(areset), .i_start(start),
        .i_cfg_w_beats_1(cfg_w), .i_cfg_px_beats_1(cfg_px), .i_cfg_blocks_1(cfg_bl),
        .o_busy(busy), .o_done(done), .o_err_tlast(err_tlast), .o_state(state),
        .o_s_axis_tready(s_tready), .i_s_axis_tvalid(s_tvalid),
        .i_s_axis_tlast(s_tlast), .i_s_axis_tdata(s_tdata),
        .i_m_w_tready(w_tready), .o_m_w_tvalid(w_tvalid), .o_m_w_tlast(w_tlast), .o_m_w_tdata(w_tdata),
        .i_m_p1_tready(p1_tready), .o_m_p1_tvalid(p1_tvalid), .o_m_p1_tlast(p1_tlast), .o_m_p1_tdata(p1_tdata),
        .i_m_p2_tready(p2_tready), .o_m_p2_tvalid(p2_tvalid), .o_m_p2_tlast(p2_tlast), .o_m_p2_tdata(p2_tdata)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [DW:0] exp_w_q[$];    // {tlast, data}
    logic [DW:0] exp_p1_q[$];
    logic [DW:0] exp_p2_q[$];
    int          exp_job_q[$];  // handshakes expected before each done pulse
    int          job_id = 0;
    bit          rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int job, input int n);
        return {job, n};
    endfunction

    // ---------------- sink ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) begin
                w_tready  = ($urandom_range(0, 99) < 60);
                p1_tready = ($urandom_range(0, 99) < 60);
                p2_tready = ($urandom_range(0, 99) < 60);
            end else begin
                w_tready  = 1'b1;
                p1_tready = 1'b1;
                p2_tready = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int hs_cnt = 0;
    int cyc = 0;
    int last_hs_cyc = -10;

    task automatic pop_cmp(input string name, input logic last, input logic [DW-1:0] data,
                           inout logic [DW:0] q[$]);
        logic [DW:0] e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected beat actual=%0h required=none", name, {last, data});
        end else begin
            e = q.pop_front();
            chk(name, {63'd0, last, data}, {63'd0, e});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (areset) begin
            hs_cnt = 0;
        end else begin
            if (w_tvalid && w_tready)   pop_cmp("w_beat", w_tlast, w_tdata, exp_w_q);
            if (p1_tvalid && p1_tready) pop_cmp("p1_beat", p1_tlast, p1_tdata, exp_p1_q);
            if (p2_tvalid && p2_tready) pop_cmp("p2_beat", p2_tlast, p2_tdata, exp_p2_q);
            if (s_tvalid) chk("tvalid_onehot", 128'(($countones({w_tvalid, p1_tvalid, p2_tvalid}) <= 1)), 128'd1);
            if (done) begin
                if (exp_job_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_pulse unexpected actual=1 required=0");
                end else begin
                    chk("done_hs_count", 128'(hs_cnt), 128'(exp_job_q.pop_front()));
                    chk("done_latency", 128'(cyc - last_hs_cyc), 128'd1);
                end
                hs_cnt = 0;
            end
            if (s_tvalid && s_tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Pushes the expected per-port beats of a whole job, then pulses start.
    task automatic start_job(input int wb, input int pb, input int bb);
        int n = 0;
        job_id++;
        for (int i = 0; i <= wb; i++) exp_w_q.push_back({(i == wb), beat_data(job_id, n++)});
        for (int b = 0; b <= bb; b++) begin
            for (int i = 0; i <= pb; i++) exp_p1_q.push_back({(i == pb), beat_data(job_id, n++)});
            for (int i = 0; i <= pb; i++) exp_p2_q.push_back({(i == pb), beat_data(job_id, n++)});
        end
        exp_job_q.push_back(n);
        cfg_w  = 16'(wb);
        cfg_px = 16'(pb);
        cfg_bl = 8'(bb);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'd1);
        chk("start_state", 128'(state), 128'd1);
        chk("start_err_clear", 128'(err_tlast), 128'd0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap);
        int n = 0;
        logic got;
        if (gap > 0 && $urandom_range(0, 99) < gap) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
            if (got) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout actual=no_ready required=ready");
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Sends beats of the current job. bad_idx flips the source tlast on one
    // beat; pause_idx issues an ignored start after that beat; stop_after
    // limits the number of beats sent (-1 = whole job).
    task automatic send_job(input int wb, input int pb, input int bb, input int gap,
                            input int bad_idx, input int pause_idx, input int stop_after);
        int n = 0;
        logic l;
        for (int seg = 0; seg < 1 + 2 * (bb + 1); seg++) begin
            int len = (seg == 0) ? wb : pb;
            for (int i = 0; i <= len; i++) begin
                if (stop_after >= 0 && n >= stop_after) return;
                l = (i == len);
                if (n == bad_idx) l = ~l;
                send_beat(beat_data(job_id, n), l, gap);
                if (n == bad_idx) chk("err_tlast_set", 128'(err_tlast), 128'd1);
                if (n == pause_idx) begin
                    cfg_w  = 16'd5;
                    cfg_px = 16'd5;
                    cfg_bl = 8'd3;
                    start  = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    chk("ignored_start_state", 128'(state), 128'd2);
                    chk("ignored_start_busy", 128'(busy), 128'd1);
                end
                n++;
            end
        end
    endtask

    task automatic check_done(input logic exp_err);
        chk("job_done", 128'(done), 128'd1);
        chk("job_busy_low", 128'(busy), 128'd0);
        chk("job_err_tlast", 128'(err_tlast), 128'(exp_err));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset state, with a source beat offered to show nothing is routed.
        s_tvalid = 1'b1;
        s_tdata  = 64'hDEAD_BEEF_0000_0001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err_tlast), 128'd0);
        chk("rst_tready", 128'(s_tready), 128'd0);
        chk("rst_tvalids", 128'({w_tvalid, p1_tvalid, p2_tvalid}), 128'd0);
        chk("rst_state", 128'(state), 128'd0);
        areset   = 1'b0;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_tready", 128'(s_tready), 128'd0);

        // T1: 4 weights, then p1,p2,p1,p2 of 2 beats; 12 handshakes.
        start_job(3, 1, 1);
        send_job(3, 1, 1, 0, -1, -1, -1);
        check_done(1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 128'(done), 128'd0);

        // T2: same config, source gaps and random sink readies.
        rnd_ready = 1'b1;
        start_job(3, 1, 1);
        send_job(3, 1, 1, 30, -1, -1, -1);
        check_done(1'b0);
        // Another shape under the same random conditions.
        start_job(2, 2, 3);
        send_job(2, 2, 3, 30, -1, -1, -1);
        check_done(1'b0);
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T3: all-zero config: 1 weight, 1 p1, 1 p2, each tlast.
        start_job(0, 0, 0);
        send_job(0, 0, 0, 0, -1, -1, -1);
        check_done(1'b0);
        @(posedge clk);
        #1;

        // T4: source tlast on weight beat 2 of 4; flag is sticky.
        start_job(3, 1, 0);
        send_job(3, 1, 0, 0, 1, -1, -1);
        check_done(1'b1);
        @(posedge clk);
        #1;
        chk("err_sticky", 128'(err_tlast), 128'd1);

        // T5: start during PIX1 ignored; start on the done cycle accepted
        // (start_job also confirms err_tlast from T4 is cleared).
        start_job(1, 1, 0);
        send_job(1, 1, 0, 0, -1, 2, -1);
        check_done(1'b0);
        start_job(0, 0, 0);
        send_job(0, 0, 0, 0, -1, -1, -1);
        check_done(1'b0);
        @(posedge clk);
        #1;

        // T6: reset in PIX2 with beat_cnt=1; no done afterwards.
        start_job(1, 1, 1);
        send_job(1, 1, 1, 0, -1, -1, 5);
        chk("pre_rst_state", 128'(state), 128'd3);
        s_tvalid = 1'b1;
        s_tdata  = 64'hAAAA_5555_0000_0006;
        areset   = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_state", 128'(state), 128'd0);
        chk("midrst_tready", 128'(s_tready), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        chk("midrst_p2_tvalid", 128'(p2_tvalid), 128'd0);
        areset   = 1'b0;
        s_tvalid = 1'b0;
        exp_w_q.delete();
        exp_p1_q.delete();
        exp_p2_q.delete();
        exp_job_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("postrst_no_done", 128'(done), 128'd0);
        end

        // A job after the reset still works.
        start_job(1, 0, 1);
        send_job(1, 0, 1, 0, -1, -1, -1);
        check_done(1'b0);
        repeat (3) @(posedge clk);
        #1;

        chk("w_q_empty", 128'(exp_w_q.size()), 128'd0);
        chk("p1_q_empty", 128'(exp_p1_q.size()), 128'd0);
        chk("p2_q_empty", 128'(exp_p2_q.size()), 128'd0);
        chk("job_q_empty", 128'(exp_job_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
